trace_line_parser: RTL and testbench

Synthesizable streaming parser for cache-simulator trace text. Accepts one ASCII character per beat, decodes lines of the form `<op> <hex address>` into an opcode/address command, and reports malformed lines with an error code and line number. Sits between the trace byte source (file reader or UART front end) and the cache controller command input. Generalises the behavioural trace reader with a parametrised address width, a configurable legal-opcode set, handshaked I/O and error recovery.

---
 rtl/trace_pkg.sv | 31 +++
 rtl/ascii_classify.sv | 23 ++
 rtl/trace_line_parser.sv | 168 ++++++++++++++++
 tb/tb_trace_line_parser.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared opcode, error and parser-state types plus ASCII constants for the trace parser
package trace_pkg;
  typedef enum logic [3:0] {
    RD_DATA   = 4'd0,
    WR_DATA   = 4'd1,
    RD_INSTR  = 4'd2,
    INVAL     = 4'd3,
    SNOOP_RFO = 4'd4,
    CLEAR     = 4'd8,
    PRINT     = 4'd9
  } op_e;
  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    BAD_OP   = 3'd1,
    BAD_CHAR = 3'd2,
    ADDR_OVF = 3'd3,
    NO_ADDR  = 3'd4
  } err_e;
  typedef enum logic [2:0] {
    LSTART = 3'd0,
    OP     = 3'd1,
    SEP    = 3'd2,
    ADDR   = 3'd3,
    TAIL   = 3'd4,
    SKIP   = 3'd5
  } state_e;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] SP  = 8'h20;
  localparam logic [7:0] TAB = 8'h09;
endpackage

// File: rtl/ascii_classify.sv
// ascii_classify: character class flags and hex nibble value for one ASCII byte
module ascii_classify
  import trace_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_ws,
  output logic       is_lf,
  output logic       is_cr,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);
  logic is_lo;
  logic is_up;
  assign is_ws  = in_char == SP || in_char == TAB;
  assign is_lf  = in_char == LF;
  assign is_cr  = in_char == CR;
  assign is_dec = in_char >= 8'h30 && in_char <= 8'h39;
  assign is_lo  = in_char >= 8'h61 && in_char <= 8'h66;
  assign is_up  = in_char >= 8'h41 && in_char <= 8'h46;
  assign is_hex = is_dec || is_lo || is_up;
  assign nibble = is_dec ? in_char[3:0] : in_char[3:0] + 4'd9;
endmodule

// File: rtl/trace_line_parser.sv
// trace_line_parser: streaming "<op> <hex addr>" line decoder with handshaked commands, error pulses and EOF handling
module trace_line_parser
  import trace_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter logic [9:0] OP_MASK = 10'b11_0001_1111,
  parameter int         LINE_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_addr,
  output logic [LINE_W-1:0] out_line,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [LINE_W-1:0] err_line,
  output logic              done,
  output logic [LINE_W-1:0] cmd_count
);
  localparam int ND = ADDR_W / 4;
  localparam int CW = $clog2(ND + 2);
  logic              is_ws;
  logic              is_lf;
  logic              is_cr;
  logic              is_dec;
  logic              is_hex;
  logic [3:0]        nib;
  logic [15:0]       legal_set;
  logic              legal;
  logic              acc;
  logic              ovf;
  logic              emit;
  err_e              err;
  logic [ADDR_W-1:0] addr_sh;
  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_op_q, out_op_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [LINE_W-1:0] out_line_q, out_line_d;
  logic              err_valid_q, err_valid_d;
  err_e              err_code_q, err_code_d;
  logic [LINE_W-1:0] err_line_q, err_line_d;
  logic              done_q, done_d;
  logic [LINE_W-1:0] cmd_q, cmd_d;
  ascii_classify u_cls (
    .in_char(in_char),
    .is_ws  (is_ws),
    .is_lf  (is_lf),
    .is_cr  (is_cr),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nib)
  );
  assign legal_set = {6'b0, OP_MASK};
  assign legal     = legal_set[nib];
  assign in_ready  = !out_valid_q || out_ready;
  assign acc       = in_valid && in_ready;
  assign ovf       = is_hex && cnt_q == CW'(ND);
  assign addr_sh   = ADDR_W'({addr_q, nib});
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    emit    = 1'b0;
    err     = ERR_NONE;
    done_d  = 1'b0;
    if (acc && in_eof) begin
      state_d = LSTART;
      emit    = state_q == ADDR || state_q == TAIL;
      err     = state_q == OP || state_q == SEP ? NO_ADDR : ERR_NONE;
      done_d  = 1'b1;
    end else if (acc && !is_cr) begin
      line_d = is_lf ? line_q + LINE_W'(1) : line_q;
      case (state_q)
        LSTART: begin
          state_d = is_ws || is_lf ? LSTART : is_dec && legal ? OP : SKIP;
          err     = is_ws || is_lf ? ERR_NONE : !is_dec ? BAD_CHAR : legal ? ERR_NONE : BAD_OP;
          op_d    = nib;
        end
        OP: begin
          state_d = is_ws ? SEP : is_lf ? LSTART : SKIP;
          err     = is_ws ? ERR_NONE : is_lf ? NO_ADDR : BAD_CHAR;
        end
        SEP: begin
          state_d = is_ws ? SEP : is_hex ? ADDR : is_lf ? LSTART : SKIP;
          err     = is_ws || is_hex ? ERR_NONE : is_lf ? NO_ADDR : BAD_CHAR;
          addr_d  = ADDR_W'(nib);
          cnt_d   = CW'(1);
        end
        ADDR: begin
          state_d = is_ws ? TAIL : is_lf ? LSTART : is_hex && !ovf ? ADDR : SKIP;
          err     = ovf ? ADDR_OVF : is_ws || is_lf || is_hex ? ERR_NONE : BAD_CHAR;
          addr_d  = is_hex ? addr_sh : addr_q;
          cnt_d   = is_hex ? cnt_q + CW'(1) : cnt_q;
          emit    = is_lf;
        end
        TAIL: begin
          state_d = is_ws ? TAIL : is_lf ? LSTART : SKIP;
          err     = is_ws || is_lf ? ERR_NONE : BAD_CHAR;
          emit    = is_lf;
        end
        default: state_d = is_lf ? LSTART : SKIP;
      endcase
    end
    out_valid_d = emit || (out_valid_q && !out_ready);
    out_op_d    = emit ? op_q : out_op_q;
    out_addr_d  = emit ? addr_q : out_addr_q;
    out_line_d  = emit ? line_q : out_line_q;
    err_valid_d = err != ERR_NONE;
    err_code_d  = err_valid_d ? err : err_code_q;
    err_line_d  = err_valid_d ? line_q : err_line_q;
    cmd_d       = cmd_q + LINE_W'(emit);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSTART;
      op_q        <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      line_q      <= LINE_W'(1);
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_addr_q  <= '0;
      out_line_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_line_q  <= '0;
      done_q      <= 1'b0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_addr_q  <= out_addr_d;
      out_line_q  <= out_line_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_line_q  <= err_line_d;
      done_q      <= done_d;
      cmd_q       <= cmd_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_addr  = out_addr_q;
  assign out_line  = out_line_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_line  = err_line_q;
  assign done      = done_q;
  assign cmd_count = cmd_q;
endmodule

// File: tb/tb_trace_line_parser.sv
// tb_trace_line_parser: randomized and directed stimulus against a line-level reference model of the trace parser
module tb_trace_line_parser;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam logic [9:0] MASK = 10'b11_0001_1111;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_char = 8'h0;
  logic          in_eof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_op;
  logic [AW-1:0] out_addr;
  logic [LW-1:0] out_line;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [LW-1:0] err_line;
  logic          done;
  logic [LW-1:0] cmd_count;
  trace_line_parser #(.ADDR_W(AW), .OP_MASK(MASK), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .in_eof(in_eof), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_addr(out_addr), .out_line(out_line), .err_valid(err_valid), .err_code(err_code),
    .err_line(err_line), .done(done), .cmd_count(cmd_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] op; logic [AW-1:0] addr; logic [LW-1:0] line;} cmd_t;
  typedef struct packed {logic [2:0] code; logic [LW-1:0] line;} err_t;
  cmd_t exp_c[$];
  cmd_t got_c[$];
  err_t exp_e[$];
  err_t got_e[$];
  byte unsigned cur[$];
  int total = 0;
  int bad = 0;
  int exp_done = 0;
  int got_done = 0;
  int exp_cmds = 0;
  int line_no = 1;
  int stalls = 0;
  logic rand_ready = 1'b0;
  logic hold_low = 1'b0;
  logic pv = 1'b0;
  cmd_t pc;
  string hx = "0123456789abcdefABCDEF";
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  function automatic bit ws(input byte unsigned c);
    return c == 8'h20 || c == 8'h09;
  endfunction
  function automatic bit dec(input byte unsigned c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction
  function automatic int hexv(input byte unsigned c);
    if (dec(c)) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction
  // Evaluates one complete line (CRs already dropped) against the text grammar.
  task automatic eval_line();
    int i = 0;
    int n = cur.size();
    int k = 0;
    logic [AW-1:0] a = '0;
    logic [3:0] op = '0;
    logic [2:0] code = 3'd0;
    bit any = 0;
    while (i < n && ws(cur[i])) i++;
    if (i < n) begin
      any = 1;
      if (!dec(cur[i])) code = 3'd2;
      else if (!MASK[hexv(cur[i])]) code = 3'd1;
      else begin
        op = 4'(hexv(cur[i]));
        i++;
        if (i == n) code = 3'd4;
        else if (!ws(cur[i])) code = 3'd2;
        else begin
          while (i < n && ws(cur[i])) i++;
          if (i == n) code = 3'd4;
          else if (hexv(cur[i]) < 0) code = 3'd2;
          else begin
            while (i < n && hexv(cur[i]) >= 0 && code == 3'd0) begin
              k++;
              if (k > AW / 4) code = 3'd3;
              a = (a << 4) | AW'(hexv(cur[i]));
              i++;
            end
            while (code == 3'd0 && i < n && ws(cur[i])) i++;
            if (code == 3'd0 && i < n) code = 3'd2;
          end
        end
      end
    end
    if (any && code != 3'd0) exp_e.push_back({code, LW'(line_no)});
    else if (any) begin
      exp_c.push_back({op, a, LW'(line_no)});
      exp_cmds++;
    end
    cur.delete();
  endtask
  task automatic model(input byte unsigned c, input logic eof);
    if (eof) begin
      eval_line();
      exp_done++;
    end else if (c == 8'h0A) begin
      eval_line();
      line_no++;
    end else if (c != 8'h0D) cur.push_back(c);
  endtask
  task automatic send(input byte unsigned c, input logic eof);
    int n = 0;
    in_valid = 1'b1;
    in_char = c;
    in_eof = eof;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", n >= 100, 0);
    stalls += n;
    @(posedge clk);
    model(c, eof);
    @(negedge clk);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
  endtask
  task automatic settle();
    int n = 0;
    in_valid = 1'b0;
    in_eof = 1'b0;
    repeat (2) @(negedge clk);
    while (out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", out_valid, 0);
    @(negedge clk);
  endtask
  task automatic compare_all(input string name);
    check({name, "_ncmd"}, got_c.size(), exp_c.size());
    foreach (exp_c[i]) if (i < got_c.size()) check({name, "_cmd"}, got_c[i], exp_c[i]);
    check({name, "_nerr"}, got_e.size(), exp_e.size());
    foreach (exp_e[i]) if (i < got_e.size()) check({name, "_err"}, got_e[i], exp_e[i]);
    check({name, "_done"}, got_done, exp_done);
    check({name, "_count"}, cmd_count, LW'(exp_cmds));
    exp_c.delete();
    got_c.delete();
    exp_e.delete();
    got_e.delete();
    exp_done = 0;
    got_done = 0;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    in_eof = 1'b0;
    #1;
    check("rst_flags", {out_valid, err_valid, done, in_ready}, 4'b0001);
    check("rst_out", {out_op, out_addr, out_line}, 0);
    check("rst_err", {err_code, err_line, cmd_count}, 0);
    cur.delete();
    line_no = 1;
    exp_cmds = 0;
    exp_c.delete();
    got_c.delete();
    exp_e.delete();
    got_e.delete();
    exp_done = 0;
    got_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic rand_line();
    if ($urandom_range(0, 9) == 0) begin
      send(8'h0A, 1'b0);
      return;
    end
    repeat ($urandom_range(0, 2)) send($urandom_range(0, 1) ? 8'h20 : 8'h09, 1'b0);
    send($urandom_range(0, 19) == 0 ? 8'h78 : 8'(48 + $urandom_range(0, 9)), 1'b0);
    if ($urandom_range(0, 14) == 0) send(8'h0D, 1'b0);
    repeat ($urandom_range(0, 2)) send($urandom_range(0, 1) ? 8'h20 : 8'h09, 1'b0);
    repeat ($urandom_range(0, 9)) send(hx[$urandom_range(0, 21)], 1'b0);
    if ($urandom_range(0, 7) == 0) send(8'h67, 1'b0);
    repeat ($urandom_range(0, 2)) send(8'h20, 1'b0);
    if ($urandom_range(0, 9) == 0) send(8'h0D, 1'b0);
    send(8'h0A, 1'b0);
  endtask
  initial forever begin
    @(posedge clk);
    #2 out_ready = hold_low ? 1'b0 : rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) pv = 1'b0;
    else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (pv) check("hold", {out_valid, out_op, out_addr, out_line}, {1'b1, pc});
      if (out_valid && out_ready) got_c.push_back({out_op, out_addr, out_line});
      if (err_valid) got_e.push_back({err_code, err_line});
      if (done) got_done++;
      pv = out_valid && !out_ready;
      pc = {out_op, out_addr, out_line};
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    do_reset();
    stalls = 0;
    send_str("0 1a2b\n");
    check("t1_latency", {out_valid, out_addr}, {1'b1, 32'h1A2B});
    send_str("2 FFFFFFFF\n");
    settle();
    check("t1_stalls", stalls, 0);
    check("t1_c0", got_c[0], {4'd0, 32'h1A2B, 16'd1});
    check("t1_c1", got_c[1], {4'd2, 32'hFFFF_FFFF, 16'd2});
    check("t1_count", cmd_count, 2);
    compare_all("t1");
    do_reset();
    send_str("\n  \t\n8 10\r\n");
    settle();
    check("t2_c0", got_c[0], {4'd8, 32'h10, 16'd3});
    check("t2_nerr", got_e.size(), 0);
    compare_all("t2");
    do_reset();
    send_str("5 40\n1 z");
    check("t3_pulse", {err_valid, err_code}, {1'b1, 3'd2});
    send_str("z\n1 123456789\n3\n");
    settle();
    check("t3_e0", got_e[0], {3'd1, 16'd1});
    check("t3_e1", got_e[1], {3'd2, 16'd2});
    check("t3_e2", got_e[2], {3'd3, 16'd3});
    check("t3_e3", got_e[3], {3'd4, 16'd4});
    check("t3_ncmd", got_c.size(), 0);
    compare_all("t3");
    do_reset();
    send_str("1 abc");
    send(8'h00, 1'b1);
    check("t4_done_valid", {done, out_valid}, 2'b11);
    settle();
    check("t4_c0", got_c[0], {4'd1, 32'hABC, 16'd1});
    compare_all("t4");
    do_reset();
    hold_low = 1'b1;
    fork
      send_str("0 1\n0 2\n");
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("t5_rise", out_valid, 1);
        repeat (5) begin
          check("t5_stall", {in_ready, out_addr}, {1'b0, 32'h1});
          @(negedge clk);
        end
        hold_low = 1'b0;
      end
    join
    settle();
    check("t5_c0", got_c[0], {4'd0, 32'h1, 16'd1});
    check("t5_c1", got_c[1], {4'd0, 32'h2, 16'd2});
    compare_all("t5");
    do_reset();
    hold_low = 1'b1;
    send_str("4 5\n");
    check("t6_pending", out_valid, 1);
    do_reset();
    hold_low = 1'b0;
    send_str("0 12");
    do_reset();
    send_str("9 0\n");
    settle();
    check("t6_c0", got_c[0], {4'd9, 32'h0, 16'd1});
    check("t6_count", cmd_count, 1);
    compare_all("t6");
    do_reset();
    rand_ready = 1'b1;
    repeat (250) rand_line();
    send_str("3 dead");
    send(8'h00, 1'b1);
    rand_ready = 1'b0;
    settle();
    compare_all("rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
